// File: rtl/mem_responder16.sv
// mem_responder16 - word-addressed 16-bit memory target for the processor's
// load/store request port. It serves single-word LW/SW accesses and LM/SM
// bursts of 1..8 consecutive words. Each transaction waits WAIT_CYCLES+1
// cycles between request accept and its first beat.
//
// Parameters
//   ADDR_W      decoded word-address bits; the array holds 2^ADDR_W words
//   WAIT_CYCLES wait states after accept (0..15)
//
// Ports
//   clk1, rst               clock; synchronous active-high reset
//   req_valid/req_ready     request handshake; req_ready is high only in IDLE
//   req_we, req_addr, req_len  write select, base word address, length-1
//   wr_valid/wr_ready/wr_data  write beat channel, accepted only in WR
//   rsp_valid/rsp_ready     read beat or write-ack handshake
//   rsp_data, rsp_last      read data (0 on write ack), final-beat marker
//   busy                    any state other than IDLE
//   addr_err                sticky flag: a request had address bits above ADDR_W
//   rsp_zero                only when MEMRSP_ZERO_FLAG_EN is defined: the
//                           presented read beat is 16'h0000
//
// Optional build macro: MEMRSP_ZERO_FLAG_EN (adds the rsp_zero output).
module mem_responder16 #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  input  logic        rsp_ready,
  output logic        busy,
  output logic        addr_err
`ifdef MEMRSP_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_WR, S_WACK} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [3:0]        r_wait;
  logic              r_rsp_valid;
  logic [15:0]       r_rsp_data;
  logic              r_rsp_last;
  logic              r_addr_err;
  logic [15:0]       r_mem [2**ADDR_W];

  logic              w_rd_hs;
  logic              w_wr_hs;
  logic              w_upper_nz;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [15:0]       w_rd_word;

  assign w_rd_hs    = (r_state == S_RD) && rsp_ready;
  assign w_wr_hs    = (r_state == S_WR) && wr_valid;
  assign w_upper_nz = (req_addr >> ADDR_W) != 16'd0;
  // Natural ADDR_W-bit overflow gives the 2^ADDR_W-1 -> 0 wrap.
  assign w_addr_inc = r_addr + 1'b1;
  // While a read beat is being consumed, fetch the following word so the
  // next beat is ready on the very next cycle.
  assign w_rd_addr  = (r_state == S_RD) ? w_addr_inc : r_addr;
  assign w_rd_word  = r_mem[w_rd_addr];

  // ---------------- FSM ----------------
  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (r_wait == 4'd0) w_state_nxt = r_we ? S_WR : S_RD;
      S_RD:   if (w_rd_hs && r_cnt == 3'd0) w_state_nxt = S_IDLE;
      S_WR: begin
        wr_ready = 1'b1;
        if (wr_valid && r_cnt == 3'd0) w_state_nxt = S_WACK;
      end
      S_WACK: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_addr      <= '0;
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_wait      <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_rsp_last  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr <= req_addr[ADDR_W-1:0];
          r_cnt  <= req_len;
          r_we   <= req_we;
          r_wait <= 4'(WAIT_CYCLES);
          if (w_upper_nz) r_addr_err <= 1'b1;
        end
        S_WAIT: begin
          if (r_wait == 4'd0) begin
            if (!r_we) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rd_word;
              r_rsp_last  <= (r_cnt == 3'd0);
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_RD: if (w_rd_hs) begin
          if (r_cnt == 3'd0) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
          end else begin
            r_addr     <= w_addr_inc;
            r_cnt      <= r_cnt - 3'd1;
            r_rsp_data <= w_rd_word;
            r_rsp_last <= (r_cnt == 3'd1);
          end
        end
        S_WR: if (wr_valid) begin
          r_addr <= w_addr_inc;
          r_cnt  <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_rsp_data  <= 16'd0;
          end
        end
        S_WACK: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Memory is not reset; the rst gate stops a beat landing on the reset edge.
  always_ff @(posedge clk1) begin
    if (!rst && w_wr_hs) r_mem[r_addr] <= wr_data;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign addr_err  = r_addr_err;

`ifdef MEMRSP_ZERO_FLAG_EN
  // r_we stays constant for the whole transaction and rsp_data is
  // registered, so this flag holds steady with the beat it describes.
  assign rsp_zero = r_rsp_valid && !r_we && (r_rsp_data == 16'd0);
`endif

endmodule

// File: tb/tb_mem_responder16.sv
module tb_mem_responder16;
  localparam int AW = 10;
  localparam int WC = 1;

  logic        clk1 = 1'b0;
  logic        rst, req_valid, req_we, wr_valid, rsp_ready, aux_en;
  logic [15:0] req_addr, wr_data;
  logic [2:0]  req_len;
  logic        req_valid_aux;
  logic        req_ready, wr_ready, rsp_valid, rsp_last, busy, addr_err;
  logic [15:0] rsp_data;
  logic        req_ready_a, wr_ready_a, rsp_valid_a, rsp_last_a, busy_a, addr_err_a;
  logic [15:0] rsp_data_a;
  logic        req_ready_b, wr_ready_b, rsp_valid_b, rsp_last_b, busy_b, addr_err_b;
  logic [15:0] rsp_data_b;
`ifdef MEMRSP_ZERO_FLAG_EN
  logic        rsp_zero, rsp_zero_a, rsp_zero_b;
`endif

  always #5 clk1 = ~clk1;
  assign req_valid_aux = req_valid & aux_en;

  mem_responder16 #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u0 (
    .clk1(clk1), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready), .busy(busy), .addr_err(addr_err)
`ifdef MEMRSP_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  mem_responder16 #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_a (
    .clk1(clk1), .rst(rst), .req_valid(req_valid_aux), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_last(rsp_last_a),
    .rsp_ready(rsp_ready), .busy(busy_a), .addr_err(addr_err_a)
`ifdef MEMRSP_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero_a)
`endif
  );

  mem_responder16 #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_b (
    .clk1(clk1), .rst(rst), .req_valid(req_valid_aux), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_last(rsp_last_b),
    .rsp_ready(rsp_ready), .busy(busy_b), .addr_err(addr_err_b)
`ifdef MEMRSP_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero_b)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_mem [1024];
  logic [15:0] wbuf [8];
  bit          err_exp = 1'b0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [2:0]  len;
    int          mode;     // 0: rsp_ready=1, 1: random, 2: 1,0,0 pattern
    logic [15:0] wbase;    // write beats carry wbase, wbase+1, ...
    bit          exp_err;  // addr_err expected after the transaction
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic pick_ready(input int mode, input int pat);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return (pat % 3) == 0;
  endfunction

  // Returns right after the accepting edge.
  task automatic issue(input bit we, input logic [15:0] a, input logic [2:0] len);
    int c = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = len;
    while (!req_ready && c < 100) begin step(); c++; end
    chk("req_accept_timeout", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic read_beats(input int base, input int len, input int mode, output int lat);
    int k = 0, cyc = 0, pat = 0, idx;
    bit stalled = 1'b0;
    logic [15:0] pd;
    logic pl;
    lat = -1;
    while (k <= len && cyc < 300) begin
      rsp_ready = pick_ready(mode, pat);
      if (rsp_valid) begin
        if (lat < 0) lat = cyc;
        if (stalled) begin
          chk("stall_data_stable", {16'd0, rsp_data}, {16'd0, pd});
          chk("stall_last_stable", {31'd0, rsp_last}, {31'd0, pl});
        end
        if (rsp_ready) begin
          idx = (base + k) % 1024;
          chk("rd_data", {16'd0, rsp_data}, {16'd0, model_mem[idx]});
          chk("rd_last", {31'd0, rsp_last}, {31'd0, (k == len)});
`ifdef MEMRSP_ZERO_FLAG_EN
          chk("rd_zero", {31'd0, rsp_zero}, {31'd0, (model_mem[idx] == 16'd0)});
`endif
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = rsp_data; pl = rsp_last;
        end
        pat++;
      end
      step(); cyc++;
    end
    chk("rd_beat_count", 32'(k), 32'(len + 1));
    chk("rd_done_idle", {30'd0, busy, rsp_valid}, 32'd0);
    chk("rd_done_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic write_beats(input int base, input int len, input int mode);
    int k = 0, cyc = 0;
    bit done = 1'b0;
    while (k <= len && cyc < 300) begin
      wr_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data  = wbuf[k];
      chk("wr_phase_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (wr_valid && wr_ready) begin
        model_mem[(base + k) % 1024] = wbuf[k];
        k++;
      end
      step(); cyc++;
    end
    wr_valid = 1'b0;
    chk("wr_beat_count", 32'(k), 32'(len + 1));
    chk("wr_ready_drop", {31'd0, wr_ready}, 32'd0);
    cyc = 0;
    while (!done && cyc < 50) begin
      rsp_ready = pick_ready(mode, cyc);
      chk("wack_valid", {31'd0, rsp_valid}, 32'd1);
      chk("wack_fields", {15'd0, rsp_last, rsp_data}, {15'd0, 1'b1, 16'd0});
`ifdef MEMRSP_ZERO_FLAG_EN
      chk("wack_zero", {31'd0, rsp_zero}, 32'd0);
`endif
      if (rsp_valid && rsp_ready) done = 1'b1;
      step(); cyc++;
    end
    chk("wack_single", {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  task automatic run_txn(input bit we, input logic [15:0] a, input logic [2:0] len, input int mode);
    int lat;
    if (a[15:10] != 6'd0) err_exp = 1'b1;
    issue(we, a, len);
    if (we) write_beats(int'(a[9:0]), int'(len), mode);
    else begin
      read_beats(int'(a[9:0]), int'(len), mode, lat);
      chk("rd_latency", 32'(lat), 32'(WC + 1));
    end
    chk("addr_err", {31'd0, addr_err}, {31'd0, err_exp});
  endtask

  initial begin
    int la, l0, lb, k, cyc, lat;
    logic [15:0] da, d0, db;
    logic [15:0] a;
    logic [2:0] len;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'd0; req_len = 3'd0;
    wr_valid = 1'b0; wr_data = 16'd0; rsp_ready = 1'b0; aux_en = 1'b1;
    step(); step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {27'd0, wr_ready, rsp_valid, rsp_last, busy, addr_err}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
`ifdef MEMRSP_ZERO_FLAG_EN
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Latency for WAIT_CYCLES 0/1/3: all three instances write then read mem[5].
    rsp_ready = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_len = 3'd0;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 40 && (busy | busy_a | busy_b); c++) step();
    chk("lat_wr_idle", {29'd0, busy, busy_a, busy_b}, 32'd0);
    wr_valid = 1'b0;
    model_mem[5] = 16'hBEEF;
    req_valid = 1'b1; req_we = 1'b0;
    step();
    req_valid = 1'b0;
    la = -1; l0 = -1; lb = -1; da = '0; d0 = '0; db = '0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid   && l0 < 0) begin l0 = c; d0 = rsp_data;   chk("lat_last_w1", {31'd0, rsp_last},   32'd1); end
      if (rsp_valid_a && la < 0) begin la = c; da = rsp_data_a; chk("lat_last_w0", {31'd0, rsp_last_a}, 32'd1); end
      if (rsp_valid_b && lb < 0) begin lb = c; db = rsp_data_b; chk("lat_last_w3", {31'd0, rsp_last_b}, 32'd1); end
      step();
    end
    chk("lat_w0", 32'(la), 32'd1);
    chk("lat_w1", 32'(l0), 32'd2);
    chk("lat_w3", 32'(lb), 32'd4);
    chk("lat_data_w0", {16'd0, da}, 32'h0000BEEF);
    chk("lat_data_w1", {16'd0, d0}, 32'h0000BEEF);
    chk("lat_data_w3", {16'd0, db}, 32'h0000BEEF);
    chk("lat_rd_idle", {29'd0, busy, busy_a, busy_b}, 32'd0);
    aux_en = 1'b0;

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < 128; i++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = 16'($urandom);
      run_txn(1'b1, 16'(i * 8), 3'd7, 1);
    end

    tbl[0] = '{1'b1, 16'h03FE, 3'd3, 0, 16'd1,    1'b0};
    tbl[1] = '{1'b0, 16'h03FE, 3'd3, 0, 16'd0,    1'b0};
    tbl[2] = '{1'b0, 16'h0000, 3'd7, 2, 16'd0,    1'b0};
    tbl[3] = '{1'b1, 16'h0005, 3'd0, 1, 16'hBEEF, 1'b0};
    tbl[4] = '{1'b0, 16'h0005, 3'd0, 0, 16'd0,    1'b0};
    tbl[5] = '{1'b1, 16'h0020, 3'd3, 1, 16'd0,    1'b0};
    tbl[6] = '{1'b0, 16'h0020, 3'd3, 1, 16'd0,    1'b0};
    tbl[7] = '{1'b0, 16'h0405, 3'd0, 0, 16'd0,    1'b1};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = tbl[i].wbase + 16'(j);
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].mode);
      chk("tbl_addr_err", {31'd0, addr_err}, {31'd0, tbl[i].exp_err});
    end

    // Second request held during an 8-beat burst.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; req_len = 3'd7;
    step();
    req_addr = 16'h0005; req_len = 3'd0;
    rsp_ready = 1'b1; k = 0; cyc = 0;
    while (k < 8 && cyc < 100) begin
      chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) begin
        chk("busy_rd_data", {16'd0, rsp_data}, {16'd0, model_mem[64 + k]});
        k++;
      end
      step(); cyc++;
    end
    chk("busy_beats", 32'(k), 32'd8);
    chk("rearm_ready", {30'd0, req_ready, busy}, 32'd2);
    step();
    req_valid = 1'b0;
    chk("second_accepted", {31'd0, busy}, 32'd1);
    read_beats(5, 0, 0, lat);
    chk("second_latency", 32'(lat), 32'(WC + 1));

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      a[9:0]   = 10'($urandom);
      a[15:10] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      len      = 3'($urandom);
      for (int j = 0; j < 8; j++)
        wbuf[j] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      run_txn(1'($urandom), a, len, int'($urandom_range(0, 2)));
    end

    // Reset three beats into an 8-beat write; wr_valid keeps going.
    issue(1'b1, 16'h0100, 3'd7);
    wr_valid = 1'b1; k = 0; cyc = 0;
    while (k < 3 && cyc < 50) begin
      wr_data = 16'hA000 + 16'(k);
      if (wr_ready) begin model_mem[256 + k] = wr_data; k++; end
      step(); cyc++;
    end
    chk("rstw_beats", 32'(k), 32'd3);
    rst = 1'b1; wr_data = 16'hA003;
    step();
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_outs", {27'd0, wr_ready, rsp_valid, rsp_last, busy, addr_err}, 32'd0);
    chk("rstw_rsp_data", {16'd0, rsp_data}, 32'd0);
    rst = 1'b0; err_exp = 1'b0; wr_data = 16'hA004;
    step();
    chk("rstw_idle", {30'd0, req_ready, busy}, 32'd2);
    wr_valid = 1'b0;
    run_txn(1'b0, 16'h0100, 3'd7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder16.md
Name: mem_responder16

Overview:
- Word-addressed 16-bit memory responder. It sits on the target side of the processor's load/store request interface.
- Serves single-word LW/SW accesses and multi-word LM/SM bursts of 1-8 consecutive words.
- Inserts programmable wait states before each transaction.
- Replaces the processor-internal data array as the target of its memory requests.

Parameters:
- ADDR_W, 10, word-address bits actually decoded; depth = 2^ADDR_W words.
- WAIT_CYCLES, 1, wait states between request accept and first beat (0..15; 0 legal).

Ports:
- clk1  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write (SW/SM), 0 = read (LW/LM).
- req_addr  in  16  base word address.
- req_len  in  3  burst length minus 1 (0 = 1 word, 7 = 8 words).
- wr_valid  in  1  write beat data present.
- wr_data  in  16  write beat data.
- wr_ready  out  1  responder accepts write beat.
- rsp_valid  out  1  read beat or write acknowledge present.
- rsp_data  out  16  read data (0 on write ack).
- rsp_last  out  1  final beat of transaction.
- rsp_ready  in  1  initiator accepts response.
- busy  out  1  transaction in progress (not IDLE).
- addr_err  out  1  sticky: a request had req_addr[15:ADDR_W] != 0.

Behaviour:
- Reset (rst sampled high at posedge clk1):
  - State goes to IDLE.
  - req_ready=1, wr_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, addr_err=0.
  - Memory contents are not reset.
- States: IDLE, WAIT, RD, WR, WACK.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready. Capture addr=req_addr[ADDR_W-1:0], cnt=req_len, we=req_we, wait counter=WAIT_CYCLES.
  - If req_addr upper bits are nonzero, set addr_err. The access proceeds on the low bits.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RD (we=0) or WR (we=1). With WAIT_CYCLES=0, WAIT lasts one cycle.
- Read timing:
  - The first rsp_valid is high in the cycle after the rising edge that is WAIT_CYCLES+1 edges after the accepting edge.
  - rsp_data=mem[addr] is registered.
- RD:
  - rsp_data, rsp_last and rsp_valid hold stable while rsp_valid&&!rsp_ready.
  - On handshake: addr+1 (mod 2^ADDR_W), cnt-1, and the next beat is presented the next cycle. Back-to-back beats are required, one per cycle, while rsp_ready stays 1.
  - rsp_last=1 on the beat where cnt==0. Handshake of the last beat returns the block to IDLE.
- WR:
  - wr_ready=1.
  - On wr_valid&&wr_ready: mem[addr]<=wr_data, addr+1 (mod 2^ADDR_W), cnt-1.
  - After the beat with cnt==0 is written, go to WACK. wr_ready drops in the same cycle.
- WACK: rsp_valid=1, rsp_last=1, rsp_data=0. Hold until rsp_ready, then go to IDLE.
- Boundaries:
  - Burst address wrap: 2^ADDR_W-1 wraps to 0 inside a burst.
  - req_ready=0 in every state except IDLE. A request presented while busy is ignored until IDLE.
  - Ready next request: req_ready rises the cycle after the final handshake. No same-cycle reaccept.
  - Read-after-write: a read issued after a write ack returns the new data.
  - Reset mid-burst aborts immediately. No further memory writes; already-written beats remain.
  - wr_valid outside WR is ignored. rsp_ready outside RD/WACK is ignored.
  - busy=1 in WAIT, RD, WR and WACK.

Optional Feature:
- Macro: MEMRSP_ZERO_FLAG_EN.
- When defined:
  - Adds output port rsp_zero (1 bit).
  - rsp_zero=1 when rsp_valid, a read beat is presented, and rsp_data==16'h0000. It gives the processor's Zero flag update for loads without a comparator.
  - rsp_zero is 0 on write acks and 0 at reset. It holds stable with rsp_data.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Single read latency:
  - Stimulus: preload mem[5]=16'hBEEF, WAIT_CYCLES=1; read addr 5, len 0, rsp_ready=1.
  - Required: rsp_valid with rsp_data=BEEF, rsp_last=1, high 2 edges after accept; IDLE next cycle.
  - Repeat with WAIT_CYCLES=0 and 3: first beat at 1 and 4 edges respectively.
- Burst write then read:
  - Stimulus: SM at addr 0x3FE, len 3, data 1,2,3,4; then LM at addr 0x3FE, len 3.
  - Required: mem[0x3FE]=1, mem[0x3FF]=2, mem[0]=3, mem[1]=4 (wrap). Single WACK. Read returns 1,2,3,4 with rsp_last only on 4.
- Backpressure:
  - Stimulus: 8-beat read with rsp_ready toggled 1,0,0,1,...
  - Required: rsp_data/rsp_last stable during stalls, no beat lost or duplicated, exactly 8 handshakes.
- Busy rejection:
  - Stimulus: second req_valid held during a burst.
  - Required: req_ready=0 throughout; second request accepted exactly one cycle after the first's final handshake.
- Address error:
  - Stimulus: read at req_addr=16'h0405 (ADDR_W=10).
  - Required: addr_err=1 and stays set; data from mem[5]; cleared only by rst.
- Reset mid-write:
  - Stimulus: SM len 7, assert rst after 3 beats, continue driving wr_valid.
  - Required: only 3 words written; all outputs at reset values the next cycle; req_ready=1.
  - With MEMRSP_ZERO_FLAG_EN: a read of a zero word gives rsp_zero=1, a nonzero word gives 0.
